// File: rtl/herculesae_vx_aes.sv
// herculesae_vx_aes_issue: issue and result-buffering stage around the V1/V2
// AES datapath. Accepts micro-ops at V0, drives one-hot datapath controls at
// V1, tracks the op through V2 and buffers aesout_v2 in a credit-protected
// FIFO presented at V3 with backpressure.
// Optional feature: define HERCULESAE_AES_FUSE_EN to issue opcodes 4/5
// (AESEMC/AESDIMC) as fused ops; otherwise they decode as illegal.
module herculesae_vx_aes_issue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req_valid_v0,
  output logic               req_ready_v0,
  input  logic [2:0]         req_op_v0,
  input  logic [127:0]       req_opa_v0,
  input  logic [127:0]       req_opb_v0,
  input  logic [TAG_W-1:0]   req_tag_v0,
  output logic               ival_v1_q,
  output logic               aese_v1_q,
  output logic               aesd_v1_q,
  output logic               aesd_or_e_v1_q,
  output logic               aesmc_v1_q,
  output logic               aesimc_v1_q,
  output logic               aesemc_v1_q,
  output logic               aesdimc_v1_q,
  output logic [127:0]       opa_v1,
  output logic [127:0]       opb_v1,
  input  logic [127:0]       aesout_v2,
  output logic               res_valid_v3,
  input  logic               res_ready_v3,
  output logic [127:0]       res_data_v3,
  output logic [TAG_W-1:0]   res_tag_v3,
  output logic               res_err_v3
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [127:0]     data;
    logic [TAG_W-1:0] tag;
    logic             err;
  } res_t;

  logic             acc;
  logic             pop;
  logic             push;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    occ_q;
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [TAG_W-1:0] tag_v1_q;
  logic             err_v1_q;
  logic             val_v2_q;
  logic [TAG_W-1:0] tag_v2_q;
  logic             err_v2_q;
  logic dec_aese, dec_aesd, dec_aesd_or_e, dec_aesmc, dec_aesimc, dec_err;
  res_t             mem [DEPTH];
  res_t             head;

  assign req_ready_v0 = (cnt_q < CW'(DEPTH));
  assign acc          = req_valid_v0 & req_ready_v0;
  assign push         = val_v2_q;
  assign pop          = res_valid_v3 & res_ready_v3;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef HERCULESAE_AES_FUSE_EN
  logic dec_aesemc, dec_aesdimc;

  // Decode opcode into one-hot datapath controls (fused ops enabled)
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    {dec_aese, dec_aesd, dec_aesd_or_e, dec_aesmc, dec_aesimc} = '0;
    {dec_aesemc, dec_aesdimc, dec_err} = '0;
    case (req_op_v0)
      3'd0:    {dec_aese, dec_aesd_or_e} = 2'b11;
      3'd1:    {dec_aesd, dec_aesd_or_e} = 2'b11;
      3'd2:    dec_aesmc = 1'b1;
      3'd3:    dec_aesimc = 1'b1;
      3'd4:    {dec_aese, dec_aesd_or_e, dec_aesemc} = 3'b111;
      3'd5:    {dec_aesd, dec_aesd_or_e, dec_aesdimc} = 3'b111;
      default: dec_err = 1'b1;
    endcase
  end

  // Fused control flops, cleared whenever nothing is accepted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aesemc_v1_q  <= 1'b0;
      aesdimc_v1_q <= 1'b0;
    end else begin
      aesemc_v1_q  <= acc & dec_aesemc;
      aesdimc_v1_q <= acc & dec_aesdimc;
    end
  end
`else
  // Decode opcode into one-hot datapath controls (fused ops illegal)
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    {dec_aese, dec_aesd, dec_aesd_or_e, dec_aesmc, dec_aesimc, dec_err} = '0;
    case (req_op_v0)
      3'd0:    {dec_aese, dec_aesd_or_e} = 2'b11;
      3'd1:    {dec_aesd, dec_aesd_or_e} = 2'b11;
      3'd2:    dec_aesmc = 1'b1;
      3'd3:    dec_aesimc = 1'b1;
      default: dec_err = 1'b1;
    endcase
  end

  assign aesemc_v1_q  = 1'b0;
  assign aesdimc_v1_q = 1'b0;
`endif

  // V1 valid, controls and side-band; an illegal op raises only ival
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!reset_n) begin
      ival_v1_q      <= 1'b0;
      aese_v1_q      <= 1'b0;
      aesd_v1_q      <= 1'b0;
      aesd_or_e_v1_q <= 1'b0;
      aesmc_v1_q     <= 1'b0;
      aesimc_v1_q    <= 1'b0;
      err_v1_q       <= 1'b0;
      tag_v1_q       <= '0;
    end else begin
      ival_v1_q      <= acc;
      aese_v1_q      <= acc & dec_aese;
      aesd_v1_q      <= acc & dec_aesd;
      aesd_or_e_v1_q <= acc & dec_aesd_or_e;
      aesmc_v1_q     <= acc & dec_aesmc;
      aesimc_v1_q    <= acc & dec_aesimc;
      err_v1_q       <= acc & dec_err;
      tag_v1_q       <= req_tag_v0;
    end
  end

  // Operands load only on accept and otherwise hold
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opa_v1 <= '0;
      opb_v1 <= '0;
    end else if (acc) begin
      opa_v1 <= req_opa_v0;
      opb_v1 <= req_opb_v0;
    end
  end

  // V2 tracking follows V1 unconditionally (the datapath never stalls)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      val_v2_q <= 1'b0;
      tag_v2_q <= '0;
      err_v2_q <= 1'b0;
    end else begin
      val_v2_q <= ival_v1_q;
      tag_v2_q <= tag_v1_q;
      err_v2_q <= err_v1_q;
    end
  end

  // Credit counter: ops in V1/V2 plus entries held in the FIFO
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      case ({acc, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; outputs are gated by valid so stale
    // entries are never visible after reset.
    if (push) mem[wr_ptr_q] <= {aesout_v2, tag_v2_q, err_v2_q};
  end

  assign head         = mem[rd_ptr_q];
  assign res_valid_v3 = (occ_q != '0);
  assign res_data_v3  = res_valid_v3 ? head.data : '0;
  assign res_tag_v3   = res_valid_v3 ? head.tag  : '0;
  assign res_err_v3   = res_valid_v3 & head.err;

  // Credits guarantee a free slot for every push
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && (occ_q == CW'(DEPTH))));

endmodule

// File: tb/tb_herculesae_vx_aes_issue.sv
// Self-checking bench for herculesae_vx_aes_issue. A behavioural stand-in for
// the V1/V2 datapath feeds aesout_v2; a scoreboard queue holds expected
// results built from the driven opcode and operands, compared on each pop.
module tb_herculesae_vx_aes_issue;

  localparam int TAG_W = 4;

  typedef struct {
    logic [127:0]     data;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  logic clk, reset_n;
  logic req_valid_v0, req_ready_v0;
  logic [2:0] req_op_v0;
  logic [127:0] req_opa_v0, req_opb_v0;
  logic [TAG_W-1:0] req_tag_v0;
  logic ival_v1_q, aese_v1_q, aesd_v1_q, aesd_or_e_v1_q, aesmc_v1_q;
  logic aesimc_v1_q, aesemc_v1_q, aesdimc_v1_q;
  logic [127:0] opa_v1, opb_v1, aesout_v2;
  logic res_valid_v3, res_ready_v3, res_err_v3;
  logic [127:0] res_data_v3;
  logic [TAG_W-1:0] res_tag_v3;

  int n_checks = 0;
  int n_pass = 0;
  int n_acc = 0;
  int n_pop = 0;
  int cyc = 0;
  int last_pop_cyc = -1;
  bit b2b_mode = 0;
  exp_t sb_q[$];

  herculesae_vx_aes_issue #(.DEPTH(4), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid_v0(req_valid_v0), .req_ready_v0(req_ready_v0),
    .req_op_v0(req_op_v0), .req_opa_v0(req_opa_v0), .req_opb_v0(req_opb_v0),
    .req_tag_v0(req_tag_v0),
    .ival_v1_q(ival_v1_q), .aese_v1_q(aese_v1_q), .aesd_v1_q(aesd_v1_q),
    .aesd_or_e_v1_q(aesd_or_e_v1_q), .aesmc_v1_q(aesmc_v1_q),
    .aesimc_v1_q(aesimc_v1_q), .aesemc_v1_q(aesemc_v1_q),
    .aesdimc_v1_q(aesdimc_v1_q),
    .opa_v1(opa_v1), .opb_v1(opb_v1), .aesout_v2(aesout_v2),
    .res_valid_v3(res_valid_v3), .res_ready_v3(res_ready_v3),
    .res_data_v3(res_data_v3), .res_tag_v3(res_tag_v3), .res_err_v3(res_err_v3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected controls {aese,aesd,aesd_or_e,aesmc,aesimc,aesemc,aesdimc}
  function automatic logic [6:0] exp_ctl(input logic [2:0] op);
    case (op)
      3'd0:    return 7'b1010000;
      3'd1:    return 7'b0110000;
      3'd2:    return 7'b0001000;
      3'd3:    return 7'b0000100;
`ifdef HERCULESAE_AES_FUSE_EN
      3'd4:    return 7'b1010010;
      3'd5:    return 7'b0110001;
`endif
      default: return 7'b0000000;
    endcase
  endfunction

  // Stand-in datapath function: zero when no operation control is set
  function automatic logic [127:0] dp_model(input logic [6:0] k,
                                            input logic [127:0] a, b);
    if (k == '0) return '0;
    return a ^ {b[63:0], b[127:64]} ^ {k, 121'b0};
  endfunction

  // Datapath stand-in: V1 controls/operands produce aesout_v2 during V2
  always_ff @(posedge clk)
    aesout_v2 <= dp_model({aese_v1_q, aesd_v1_q, aesd_or_e_v1_q, aesmc_v1_q,
                           aesimc_v1_q, aesemc_v1_q, aesdimc_v1_q},
                          opa_v1, opb_v1);

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Scoreboard: pop/compare first, then record any accept at the coming edge
  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (res_valid_v3 && res_ready_v3) begin
        n_pop++;
        if (sb_q.size() == 0) begin
          check("spurious_pop", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("res_data", res_data_v3, e.data);
          check("res_tag", res_tag_v3, e.tag);
          check("res_err", res_err_v3, e.err);
          if (b2b_mode && last_pop_cyc >= 0) check("b2b_gap", cyc - last_pop_cyc, 1);
          last_pop_cyc = cyc;
        end
      end
      if (req_valid_v0 && req_ready_v0) begin
        e.data = dp_model(exp_ctl(req_op_v0), req_opa_v0, req_opb_v0);
        e.tag  = req_tag_v0;
        e.err  = (exp_ctl(req_op_v0) == '0);
        sb_q.push_back(e);
        n_acc++;
      end
    end
  end

  task automatic drive(input logic [2:0] op, input logic [TAG_W-1:0] tag,
                       input logic [127:0] a, b);
    req_valid_v0 = 1'b1;
    req_op_v0    = op;
    req_tag_v0   = tag;
    req_opa_v0   = a;
    req_opb_v0   = b;
  endtask

  task automatic idle();
    req_valid_v0 = 1'b0;
  endtask

  // Present one op and wait (bounded) for its accept; returns stalled cycles
  task automatic issue(input logic [2:0] op, input logic [TAG_W-1:0] tag,
                       input logic [127:0] a, b, output int stalls);
    logic done;
    done = 1'b0;
    stalls = 0;
    drive(op, tag, a, b);
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = req_ready_v0;
      @(posedge clk); #1;
      if (!done) stalls++;
    end
    if (!done) check("issue_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check("drain", sb_q.size(), 0);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    int st, tot, base;
    reset_n = 1'b0;
    res_ready_v3 = 1'b1;
    idle();
    req_op_v0 = '0; req_tag_v0 = '0; req_opa_v0 = '0; req_opb_v0 = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ival", ival_v1_q, 0);
    check("rst_ctl", {aese_v1_q, aesd_v1_q, aesd_or_e_v1_q, aesmc_v1_q,
                      aesimc_v1_q, aesemc_v1_q, aesdimc_v1_q}, 0);
    check("rst_opa", opa_v1, 0);
    check("rst_res", {res_valid_v3, res_err_v3, res_tag_v3, res_data_v3}, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_ready", req_ready_v0, 1);
    @(posedge clk); #1;

    // Single AESE with latency check
    issue(3'd0, 4'd3, 128'h193de3bea0f4e22b9ac68d2ae9f84808, '0, st);
    idle();
    check("lat_ival", ival_v1_q, 1);
    @(posedge clk); #1;
    check("lat_n2_valid", res_valid_v3, 0);
    @(posedge clk); #1;
    check("lat_n3_valid", res_valid_v3, 1);
    wait_drain();

    // Every opcode in isolation: V1 controls
    for (int op = 0; op < 8; op++) begin
      issue(3'(op), 4'(op), rnd128(), rnd128(), st);
      idle();
      check("op_ival", ival_v1_q, 1);
      check("op_ctl", {aese_v1_q, aesd_v1_q, aesd_or_e_v1_q, aesmc_v1_q,
                       aesimc_v1_q, aesemc_v1_q, aesdimc_v1_q}, exp_ctl(3'(op)));
      @(posedge clk); #1;
      check("op_ctl_clear", ival_v1_q, 0);
    end
    wait_drain();

    // Back-to-back: 8 ops, no stalls, consecutive pops in tag order
    b2b_mode = 1; last_pop_cyc = -1; tot = 0; base = n_pop;
    for (int i = 0; i < 8; i++) begin
      issue(3'(i % 4), 4'(i), rnd128(), rnd128(), st);
      tot += st;
    end
    idle();
    wait_drain();
    b2b_mode = 0;
    check("b2b_stalls", tot, 0);
    check("b2b_pops", n_pop - base, 8);

    // Illegal op between two legal ops
    issue(3'd0, 4'd8, rnd128(), rnd128(), st);
    issue(3'd6, 4'd9, rnd128(), rnd128(), st);
    issue(3'd1, 4'd10, rnd128(), rnd128(), st);
    idle();
    wait_drain();

    // Backpressure: exactly 4 accepts, head stable, ready back after first pop
    res_ready_v3 = 1'b0;
    base = n_acc;
    for (int i = 0; i < 4; i++) issue(3'(i), 4'(i + 4), rnd128(), rnd128(), st);
    drive(3'd2, 4'd15, rnd128(), rnd128());
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_ready_low", req_ready_v0, 0);
      check("bp_head", res_data_v3, sb_q[0].data);
      check("bp_valid", res_valid_v3, 1);
      @(posedge clk); #1;
    end
    check("bp_accepts", n_acc - base, 4);
    res_ready_v3 = 1'b1;
    @(negedge clk);
    check("bp_ready_m", req_ready_v0, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_ready_m1", req_ready_v0, 1);
    @(posedge clk); #1;
    idle();
    wait_drain();

    // Reset mid-operation with 3 ops in flight
    res_ready_v3 = 1'b0;
    for (int i = 0; i < 3; i++) issue(3'(i), 4'(i), rnd128(), rnd128(), st);
    idle();
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", res_valid_v3, 0);
    check("mid_rst_ival", ival_v1_q, 0);
    sb_q.delete();
    @(posedge clk); #3;
    reset_n = 1'b1;
    res_ready_v3 = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", req_ready_v0, 1);
    base = n_pop;
    repeat (8) @(posedge clk);
    #1;
    check("mid_rst_no_stale", n_pop - base, 0);
    issue(3'd4, 4'd12, rnd128(), rnd128(), st);
    idle();
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
